// File: rtl/puzzle_run_checker.sv
// Clocked harness around one puzzle run: launches it, records the colours of the
// falling balls, and grades the recorded sequence against an expected pattern.
module puzzle_run_checker #(
    parameter int MAX_BALLS                   = 16,
    parameter int EXPECT_LEN                  = 8,
    parameter logic [EXPECT_LEN-1:0] EXPECT_PAT = 8'b10101010,
    parameter int TIMEOUT                     = 1024,
    localparam int CW                         = $clog2(MAX_BALLS + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 go,
    output logic                 puzzle_start,
    input  logic                 ball_strobe,
    input  logic                 ball_colour,
    input  logic                 puzzle_stopped,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic                 timeout,
    output logic [CW-1:0]        ball_count,
    output logic [MAX_BALLS-1:0] record
);

    localparam int IW = $clog2(MAX_BALLS);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] MAX_C   = CW'(MAX_BALLS);
    localparam logic [CW-1:0] EXP_C   = CW'(EXPECT_LEN);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
    localparam logic [MAX_BALLS-1:0] EXP_EXT = MAX_BALLS'(EXPECT_PAT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        RUN    = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic                   puzzle_start_q, puzzle_start_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   pass_q, pass_d;
    logic                   timeout_q, timeout_d;
    logic [CW-1:0]          ball_count_q, ball_count_d;
    logic [MAX_BALLS-1:0]   record_q, record_d;
    logic [TW-1:0]          idle_q, idle_d;
    logic                   mismatch_q, mismatch_d;
    logic                   overflow_q, overflow_d;
    logic [IW-1:0]          slot;

    assign slot = ball_count_q[IW-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            puzzle_start_q <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            pass_q         <= 1'b0;
            timeout_q      <= 1'b0;
            ball_count_q   <= '0;
            record_q       <= '0;
            idle_q         <= '0;
            mismatch_q     <= 1'b0;
            overflow_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            puzzle_start_q <= puzzle_start_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            pass_q         <= pass_d;
            timeout_q      <= timeout_d;
            ball_count_q   <= ball_count_d;
            record_q       <= record_d;
            idle_q         <= idle_d;
            mismatch_q     <= mismatch_d;
            overflow_q     <= overflow_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        puzzle_start_d = 1'b0;
        pass_d         = pass_q;
        timeout_d      = timeout_q;
        ball_count_d   = ball_count_q;
        record_d       = record_q;
        idle_d         = idle_q;
        mismatch_d     = mismatch_q;
        overflow_d     = overflow_q;

        case (state_q)
            IDLE, DONE: begin
                if (go) begin
                    state_d        = LAUNCH;
                    puzzle_start_d = 1'b1;
                    pass_d         = 1'b0;
                    timeout_d      = 1'b0;
                    ball_count_d   = '0;
                    record_d       = '0;
                    idle_d         = '0;
                    mismatch_d     = 1'b0;
                    overflow_d     = 1'b0;
                end
            end
            LAUNCH: begin
                state_d = RUN;
            end
            RUN: begin
                // A ball arriving with the stop flag is recorded before grading.
                if (ball_strobe) begin
                    idle_d = '0;
                    if (ball_count_q < MAX_C) begin
                        record_d[slot] = ball_colour;
                        ball_count_d   = ball_count_q + CW'(1);
                    end else begin
                        overflow_d = 1'b1;
                    end
                    if ((ball_count_q < EXP_C) && (ball_colour != EXP_EXT[slot])) begin
                        mismatch_d = 1'b1;
                    end
                end else begin
                    idle_d = idle_q + TW'(1);
                end

                if (puzzle_stopped) begin
                    state_d   = DONE;
                    timeout_d = 1'b0;
                    pass_d    = !mismatch_d && !overflow_d && (ball_count_d == EXP_C);
                end else if (!ball_strobe && (idle_d == TO_LAST)) begin
                    state_d   = DONE;
                    timeout_d = 1'b1;
                    pass_d    = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == LAUNCH) || (state_d == RUN);
        done_d = (state_d == DONE);
    end

    assign puzzle_start = puzzle_start_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign pass         = pass_q;
    assign timeout      = timeout_q;
    assign ball_count   = ball_count_q;
    assign record       = record_q;

endmodule

// File: tb/tb_puzzle_run_checker.sv
// Self-checking bench for puzzle_run_checker: directed vector table, corner-case
// sequences and randomized runs graded by a sequence-level reference model.
module tb_puzzle_run_checker;

    localparam int MAX_BALLS  = 16;
    localparam int EXPECT_LEN = 8;
    localparam logic [7:0] EXPECT_PAT = 8'b10101010;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        go;
    logic        puzzle_start;
    logic        ball_strobe;
    logic        ball_colour;
    logic        puzzle_stopped;
    logic        busy;
    logic        done;
    logic        pass;
    logic        timeout;
    logic [4:0]  ball_count;
    logic [15:0] record;

    int checks = 0;
    int errors = 0;

    puzzle_run_checker dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .go             (go),
        .puzzle_start   (puzzle_start),
        .ball_strobe    (ball_strobe),
        .ball_colour    (ball_colour),
        .puzzle_stopped (puzzle_stopped),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .timeout        (timeout),
        .ball_count     (ball_count),
        .record         (record)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          n;
        logic [31:0] colours;
        bit          coincide;
        bit          exp_pass;
        int          exp_count;
        logic [15:0] exp_record;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected result of a run, computed from the list of ball colours alone.
    task automatic model(input int n, input logic [31:0] c, output bit p,
                         output int cnt, output logic [15:0] rec);
        bit mism;
        cnt  = (n > MAX_BALLS) ? MAX_BALLS : n;
        rec  = '0;
        mism = 1'b0;
        for (int i = 0; i < cnt; i++) rec[i] = c[i];
        for (int i = 0; i < n && i < EXPECT_LEN; i++)
            if (c[i] != EXPECT_PAT[i]) mism = 1'b1;
        p = !mism && (n <= MAX_BALLS) && (cnt == EXPECT_LEN);
    endtask

    task automatic launch();
        @(negedge clk);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        check("start_pulse", puzzle_start, 1);
        check("launch_busy", busy, 1);
        check("launch_done_low", done, 0);
        check("launch_cnt_clear", ball_count, 0);
        check("launch_rec_clear", record, 0);
        @(negedge clk);
        check("start_one_cycle", puzzle_start, 0);
    endtask

    task automatic run_balls(input int n, input logic [31:0] c, input bit coincide,
                             input int gap_max, input bit rand_go);
        for (int i = 0; i < n; i++) begin
            ball_strobe = 1'b1;
            ball_colour = c[i];
            if (coincide && i == n - 1) puzzle_stopped = 1'b1;
            if (rand_go) go = 1'($urandom % 2);
            @(negedge clk);
            ball_strobe = 1'b0;
            go          = 1'b0;
            if (!(coincide && i == n - 1))
                repeat ($urandom_range(0, gap_max)) @(negedge clk);
        end
        if (!(coincide && n > 0)) begin
            puzzle_stopped = 1'b1;
            @(negedge clk);
        end
        puzzle_stopped = 1'b0;
    endtask

    task automatic check_result(input string tag, input bit p, input int cnt,
                                input logic [15:0] rec);
        check({tag, "_done"}, done, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_pass"}, pass, p);
        check({tag, "_timeout"}, timeout, 0);
        check({tag, "_count"}, ball_count, cnt);
        check({tag, "_record"}, record, rec);
    endtask

    vec_t vecs[8];

    initial begin
        bit          mp;
        int          mc;
        logic [15:0] mr;
        int          k;

        vecs[0] = '{8,  32'h000AA,   1'b0, 1'b1, 8,  16'h00AA};
        vecs[1] = '{8,  32'h000A2,   1'b0, 1'b0, 8,  16'h00A2};
        vecs[2] = '{7,  32'h0002A,   1'b0, 1'b0, 7,  16'h002A};
        vecs[3] = '{17, 32'h1AAAA,   1'b0, 1'b0, 16, 16'hAAAA};
        vecs[4] = '{8,  32'h000AA,   1'b1, 1'b1, 8,  16'h00AA};
        vecs[5] = '{0,  32'h00000,   1'b0, 1'b0, 0,  16'h0000};
        vecs[6] = '{8,  32'h000FF,   1'b0, 1'b0, 8,  16'h00FF};
        vecs[7] = '{9,  32'h001AA,   1'b0, 1'b0, 9,  16'h01AA};

        rst_n          = 1'b0;
        go             = 1'b0;
        ball_strobe    = 1'b0;
        ball_colour    = 1'b0;
        puzzle_stopped = 1'b0;
        #1;
        check("reset_outputs", {puzzle_start, busy, done, pass, timeout, ball_count, record}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 8; v++) begin
            launch();
            run_balls(vecs[v].n, vecs[v].colours, vecs[v].coincide, 1, 1'b0);
            check_result($sformatf("vec%0d", v), vecs[v].exp_pass, vecs[v].exp_count,
                         vecs[v].exp_record);
            ball_strobe = 1'b1;
            ball_colour = 1'b1;
            @(negedge clk);
            ball_strobe = 1'b0;
            check($sformatf("vec%0d_strobe_in_done", v), ball_count, vecs[v].exp_count);
        end

        // Stop flag already high through the launch cycle: run ends empty in first RUN cycle.
        puzzle_stopped = 1'b1;
        @(negedge clk);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        check("early_stop_start", puzzle_start, 1);
        @(negedge clk);
        check("early_stop_run_busy", busy, 1);
        check("early_stop_not_done", done, 0);
        @(negedge clk);
        puzzle_stopped = 1'b0;
        check_result("early_stop", 1'b0, 0, 16'h0000);

        // No activity at all: the run is aborted after about TIMEOUT idle cycles.
        launch();
        k = 0;
        while (!done && k < 1100) begin
            @(negedge clk);
            k++;
        end
        check("timeout_window", (k >= 1000 && k <= 1030), 1);
        check("timeout_done", done, 1);
        check("timeout_flag", timeout, 1);
        check("timeout_pass", pass, 0);

        // Reset in the middle of a run, then a clean run afterwards.
        launch();
        for (int i = 0; i < 3; i++) begin
            ball_strobe = 1'b1;
            ball_colour = EXPECT_PAT[i];
            @(negedge clk);
        end
        ball_strobe = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrun_reset_outputs", {puzzle_start, busy, done, pass, timeout, ball_count, record}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("after_reset_idle", {busy, done}, 0);
        launch();
        run_balls(8, 32'hAA, 1'b0, 0, 1'b0);
        check_result("after_reset", 1'b1, 8, 16'h00AA);

        // Randomized runs, with go toggled while busy to show it is ignored.
        for (int r = 0; r < 40; r++) begin
            int          n;
            logic [31:0] c;
            bit          co;
            n  = $urandom_range(0, 18);
            c  = $urandom;
            if (($urandom % 3) == 0) c[7:0] = EXPECT_PAT;
            if (($urandom % 3) == 0) n = EXPECT_LEN;
            co = (n > 0) && (($urandom % 2) == 1);
            model(n, c, mp, mc, mr);
            launch();
            run_balls(n, c, co, 3, 1'b1);
            check_result($sformatf("rand%0d", r), mp, mc, mr);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
